// File: rtl/s2cif_call_arb_if.sv
// Call/response channel between the arbiter and the s2cif bridge.
// Latency: none, plain wires grouped with direction views.
// Backpressure: call_valid/call_ready handshake; rsp_valid is a strobe with no ready.
interface s2cif_call_arb_if #(
    parameter int DW = 32
);
    logic          call_valid;
    logic          call_ready;
    logic [7:0]    call_id;
    logic [7:0]    call_fn;
    logic [DW-1:0] call_data;
    logic          rsp_valid;
    logic [31:0]   rsp_ret;
    logic [DW-1:0] rsp_data;

    // Arbiter side: presents calls, consumes responses.
    modport master (
        output call_valid, call_id, call_fn, call_data,
        input  call_ready, rsp_valid, rsp_ret, rsp_data
    );

    // Bridge side: accepts calls, produces responses.
    modport slave (
        input  call_valid, call_id, call_fn, call_data,
        output call_ready, rsp_valid, rsp_ret, rsp_data
    );
endinterface

// File: rtl/s2cif_call_arb.sv
// Round-robin sharing of one s2cif call channel among NREQ requesters, one call in flight.
// Latency: call_valid 1 cycle after an eligible req; done 1 cycle after rsp_valid (>=3 cycles/call).
// Backpressure: call held stable until call_ready; requesters wait (req level) until gnt.
module s2cif_call_arb #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int ID_BASE = 0,
    parameter int TO_CYC  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*8-1:0]  req_fn,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    eod_clr,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [31:0]        done_ret,
    output logic [DW-1:0]      done_data,
    output logic [NREQ-1:0]    eod,
    output logic               err,
    output logic [7:0]         err_id,
    s2cif_call_arb_if.master   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   nxt_ptr;
    logic            any;
    logic [15:0]     cnt;
    logic [NREQ-1:0] elig;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign elig = req & ~eod;

    // Pick the first eligible requester at or after the pointer, wrapping around.
    always_comb begin
        any  = 1'b0;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig[(int'(ptr) + k) % NREQ]) begin
                any  = 1'b1;
                pick = IW'((int'(ptr) + k) % NREQ);
            end
        end
        nxt_ptr = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    end

    // Sequencer: grant, issue, wait for response or timeout, report back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            idx            <= '0;
            cnt            <= '0;
            gnt            <= '0;
            done           <= '0;
            done_ret       <= '0;
            done_data      <= '0;
            eod            <= '0;
            err            <= 1'b0;
            err_id         <= '0;
            bus.call_valid <= 1'b0;
            bus.call_id    <= '0;
            bus.call_fn    <= '0;
            bus.call_data  <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            eod  <= eod & ~eod_clr;
            case (state)
                IDLE: begin
                    if (any) begin
                        idx            <= pick;
                        gnt            <= onehot(pick);
                        bus.call_valid <= 1'b1;
                        bus.call_id    <= 8'(ID_BASE + int'(pick));
                        bus.call_fn    <= req_fn[pick*8 +: 8];
                        bus.call_data  <= req_data[pick*DW +: DW];
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.call_ready) begin
                        bus.call_valid <= 1'b0;
                        cnt            <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the timeout cycle takes priority.
                    if (bus.rsp_valid) begin
                        done      <= onehot(idx);
                        done_ret  <= bus.rsp_ret;
                        done_data <= bus.rsp_data;
                        if (bus.rsp_ret[31]) begin
                            // Set beats a same-cycle clear.
                            eod <= (eod & ~eod_clr) | onehot(idx);
                        end else if (|bus.rsp_ret) begin
                            err <= 1'b1;
                            if (!err) err_id <= bus.call_id;
                        end
                        ptr   <= nxt_ptr;
                        state <= IDLE;
                    end else if (cnt == 16'(TO_CYC - 1)) begin
                        done      <= onehot(idx);
                        done_ret  <= 32'd1;
                        done_data <= '0;
                        err       <= 1'b1;
                        if (!err) err_id <= bus.call_id;
                        ptr   <= nxt_ptr;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s2cif_call_arb.sv
// Scoreboard bench: transaction-level round-robin model feeds expected grants/calls/dones.
// Latency: not checked cycle-exactly; ordering and values are.
// Backpressure: bridge responder inserts random call_ready and response delays.
module tb_s2cif_call_arb;
    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int ID_BASE = 0;
    localparam int TO_CYC  = 4;

    typedef struct packed {
        logic [7:0]    id;
        logic [7:0]    fn;
        logic [DW-1:0] data;
    } call_t;

    typedef struct packed {
        logic [7:0]    idx;
        logic [31:0]   ret;
        logic [DW-1:0] data;
    } done_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*8-1:0]  req_fn = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    eod_clr = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [31:0]        done_ret;
    logic [DW-1:0]      done_data;
    logic [NREQ-1:0]    eod;
    logic               err;
    logic [7:0]         err_id;

    s2cif_call_arb_if #(.DW(DW)) bus ();

    s2cif_call_arb #(.NREQ(NREQ), .DW(DW), .ID_BASE(ID_BASE), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_fn(req_fn), .req_data(req_data),
        .eod_clr(eod_clr), .gnt(gnt), .done(done), .done_ret(done_ret),
        .done_data(done_data), .eod(eod), .err(err), .err_id(err_id), .bus(bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    n_done = 0;
    int    n_call = 0;
    int    exp_gnt[$];
    call_t exp_call[$];
    done_t exp_done[$];

    // Per-requester stimulus and bridge behaviour for the current batch.
    logic [7:0]    b_fn[NREQ];
    logic [DW-1:0] b_data[NREQ];
    int            pl_ret[NREQ];
    logic [DW-1:0] pl_rdata[NREQ];
    int            pl_delay[NREQ];
    int            pl_rdy[NREQ];

    // Reference model state.
    int              m_ptr = 0;
    logic [NREQ-1:0] m_eod = '0;
    logic            m_err = 1'b0;
    logic [7:0]      m_err_id = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: pops and compares whenever the DUT presents gnt, a call handshake or done.
    initial begin
        int    e;
        call_t c;
        done_t d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt != '0) begin
                    if (exp_gnt.size() == 0) fail("unexpected_gnt");
                    else begin
                        e = exp_gnt.pop_front();
                        chk("gnt", 64'(gnt), 64'(1) << e);
                    end
                end
                if (bus.call_valid && bus.call_ready) begin
                    n_call++;
                    if (exp_call.size() == 0) fail("unexpected_call");
                    else begin
                        c = exp_call.pop_front();
                        chk("call_id", 64'(bus.call_id), 64'(c.id));
                        chk("call_fn", 64'(bus.call_fn), 64'(c.fn));
                        chk("call_data", 64'(bus.call_data), 64'(c.data));
                    end
                end
                if (done != '0) begin
                    n_done++;
                    if (exp_done.size() == 0) fail("unexpected_done");
                    else begin
                        d = exp_done.pop_front();
                        chk("done_vec", 64'(done), 64'(1) << d.idx);
                        chk("done_ret", 64'(done_ret), 64'(d.ret));
                        chk("done_data", 64'(done_data), 64'(d.data));
                    end
                end
            end
        end
    end

    // Bridge responder: accepts after pl_rdy cycles, responds pl_delay cycles into the wait.
    initial begin
        int i;
        bus.call_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_ret    = '0;
        bus.rsp_data   = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.call_valid && !rst) begin
                i = int'(bus.call_id) - ID_BASE;
                if (i < 0 || i >= NREQ) i = 0;
                repeat (pl_rdy[i]) begin @(posedge clk); #1; end
                bus.call_ready = 1'b1;
                @(posedge clk); #1;
                bus.call_ready = 1'b0;
                if (pl_delay[i] < TO_CYC) begin
                    repeat (pl_delay[i]) begin @(posedge clk); #1; end
                    bus.rsp_valid = 1'b1;
                    bus.rsp_ret   = 32'(pl_ret[i]);
                    bus.rsp_data  = pl_rdata[i];
                    @(posedge clk); #1;
                    bus.rsp_valid = 1'b0;
                    bus.rsp_ret   = $urandom;
                    bus.rsp_data  = $urandom;
                end
            end
        end
    end

    task automatic plan_default();
        for (int i = 0; i < NREQ; i++) begin
            b_fn[i]     = 8'($urandom);
            b_data[i]   = $urandom;
            pl_ret[i]   = 0;
            pl_rdata[i] = $urandom;
            pl_delay[i] = 0;
            pl_rdy[i]   = 0;
        end
    endtask

    task automatic plan_random();
        int r;
        for (int i = 0; i < NREQ; i++) begin
            b_fn[i]     = 8'($urandom);
            b_data[i]   = $urandom;
            pl_rdata[i] = $urandom;
            r = int'($urandom_range(0, 9));
            if (r == 7)      pl_ret[i] = -int'($urandom_range(1, 1000));
            else if (r == 8) pl_ret[i] = int'($urandom_range(1, 50));
            else             pl_ret[i] = 0;
            pl_delay[i] = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, 3))
                                                     : int'($urandom_range(4, 5));
            pl_rdy[i]   = ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(0, 2));
        end
    endtask

    // Holds req until granted; slices of idle requesters keep changing meanwhile.
    task automatic wait_done(input int target);
        int c;
        c = 0;
        while (n_done < target && c < 3000) begin
            @(negedge clk);
            c++;
            req = req & ~gnt;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    req_fn[i*8 +: 8]    = 8'($urandom);
                    req_data[i*DW +: DW] = $urandom;
                end
            end
        end
        if (n_done < target) fail("timeout_waiting_done");
    endtask

    // Post a batch of requests; the model derives the full grant/response sequence.
    task automatic run_batch(input logic [NREQ-1:0] pend);
        logic [NREQ-1:0] p;
        int              pick, ncalls, r;
        logic [DW-1:0]   d;
        call_t           cc;
        done_t           dd;
        p = pend;
        ncalls = 0;
        pick = 0;
        while (pick >= 0) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++)
                if (pick < 0 && p[(m_ptr + k) % NREQ] && !m_eod[(m_ptr + k) % NREQ])
                    pick = (m_ptr + k) % NREQ;
            if (pick >= 0) begin
                p[pick] = 1'b0;
                ncalls++;
                exp_gnt.push_back(pick);
                cc.id = 8'(ID_BASE + pick); cc.fn = b_fn[pick]; cc.data = b_data[pick];
                exp_call.push_back(cc);
                if (pl_delay[pick] >= TO_CYC) begin r = 1; d = '0; end
                else begin r = pl_ret[pick]; d = pl_rdata[pick]; end
                dd.idx = 8'(pick); dd.ret = 32'(r); dd.data = d;
                exp_done.push_back(dd);
                if (r < 0) m_eod[pick] = 1'b1;
                if (r > 0) begin
                    if (!m_err) m_err_id = 8'(ID_BASE + pick);
                    m_err = 1'b1;
                end
                m_ptr = (pick + 1) % NREQ;
            end
        end
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                req_fn[i*8 +: 8]    = b_fn[i];
                req_data[i*DW +: DW] = b_data[i];
            end
        end
        req = pend;
        wait_done(n_done + ncalls);
        if (ncalls == 0) repeat (5) @(negedge clk);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("eod", 64'(eod), 64'(m_eod));
        chk("err", 64'(err), 64'(m_err));
        chk("err_id", 64'(err_id), 64'(m_err_id));
        chk("queues_drained", 64'(exp_gnt.size() + exp_call.size() + exp_done.size()), 64'(0));
    endtask

    task automatic pulse_clr(input logic [NREQ-1:0] mask);
        @(negedge clk);
        eod_clr = mask;
        m_eod   = m_eod & ~mask;
        @(negedge clk);
        eod_clr = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({gnt, done, eod, err, err_id, bus.call_valid}), 64'(0));
        chk({tag, "_call"}, 64'({bus.call_id, bus.call_fn}), 64'(0));
        chk({tag, "_call_data"}, 64'(bus.call_data), 64'(0));
        chk({tag, "_done_ret"}, 64'(done_ret), 64'(0));
        chk({tag, "_done_data"}, 64'(done_data), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_eod = '0; m_err = 1'b0; m_err_id = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int    c, saved;
        call_t cc;
        plan_default();
        repeat (2) @(negedge clk);
        check_reset_outputs("init");
        rst = 1'b0;

        // Single requester.
        plan_default();
        b_fn[2] = 8'd0; b_data[2] = 32'd5; pl_rdata[2] = 32'd1; pl_rdy[2] = 1;
        run_batch(4'b0100);

        // Full rotation, twice.
        plan_default();
        run_batch(4'b1111);
        run_batch(4'b1111);

        // Response on the last cycle before timeout wins; err stays clear.
        plan_default();
        pl_delay[2] = TO_CYC - 1;
        run_batch(4'b0100);

        // End-of-data masking and clearing.
        plan_default();
        pl_ret[1] = -1;
        run_batch(4'b1111);
        plan_default();
        run_batch(4'b1111);
        run_batch(4'b1111);
        pulse_clr(4'b0010);
        plan_default();
        run_batch(4'b1111);

        // First error retained.
        plan_default();
        pl_ret[0] = 3;
        run_batch(4'b0001);
        plan_default();
        pl_ret[3] = 7;
        run_batch(4'b1000);

        // Timeout after reset clears the error state.
        do_reset();
        plan_default();
        pl_delay[2] = TO_CYC;
        run_batch(4'b0100);

        // Long call_ready stall while idle requesters' data churn.
        plan_default();
        pl_rdy[0] = 10; pl_rdy[3] = 10;
        run_batch(4'b1001);

        // Randomized batches.
        for (int n = 0; n < 40; n++) begin
            plan_random();
            if ($urandom_range(0, 3) == 0) pulse_clr(NREQ'($urandom));
            run_batch(NREQ'($urandom));
        end

        // Reset in the middle of a call: no done, arbitration restarts at requester 0.
        pulse_clr('1);
        plan_default();
        pl_delay[1] = TO_CYC + 1;
        exp_gnt.push_back(1);
        cc.id = 8'(ID_BASE + 1); cc.fn = b_fn[1]; cc.data = b_data[1];
        exp_call.push_back(cc);
        saved = n_call;
        @(negedge clk);
        req_fn[8 +: 8]   = b_fn[1];
        req_data[DW +: DW] = b_data[1];
        req = 4'b0010;
        c = 0;
        while (n_call == saved && c < 100) begin @(negedge clk); c++; end
        if (n_call == saved) fail("timeout_waiting_call");
        saved = n_done;
        do_reset();
        repeat (8) @(negedge clk);
        chk("no_done_after_rst", 64'(n_done), 64'(saved));
        plan_default();
        run_batch(4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/s2cif_call_arb.md
Name: s2cif_call_arb

Overview:
- Round-robin arbiter and sequencer that shares one s2cif function-call channel among NREQ bus-functional drivers and monitors.
- Each requester posts one call (function number plus argument data). The arbiter issues the calls one at a time over a valid/ready call port and waits for the response.
- It routes the return code and data back to the owning requester.
- It tracks per-requester end-of-data (ret<0) and flags protocol errors (ret>0 or timeout).

Parameters:
NREQ, 4, number of requesters (2..16)
DW, 32, call argument/return data width
ID_BASE, 0, call_id issued for requester 0; requester i uses ID_BASE+i
TO_CYC, 255, max cycles waiting for rsp_valid before timeout (1..65535)

Ports:
clk  input  1  clock
rst  input  1  reset
req  input  NREQ  per-requester call request, level, held until gnt
req_fn  input  NREQ*8  function number, slice i for requester i
req_data  input  NREQ*DW  call argument, slice i for requester i
eod_clr  input  NREQ  one-cycle pulse, clears eod[i]
gnt  output  NREQ  one-hot, one-cycle pulse: request accepted and latched
done  output  NREQ  one-hot, one-cycle pulse: response valid for requester i
done_ret  output  32  signed return code, qualified by |done
done_data  output  DW  return data, qualified by |done
eod  output  NREQ  sticky end-of-data mask
err  output  1  sticky error flag
err_id  output  8  call_id of the first error
call_valid  output  1  call presented to bridge
call_ready  input  1  bridge accepts call
call_id  output  8  target id
call_fn  output  8  function number
call_data  output  DW  argument
rsp_valid  input  1  bridge response strobe
rsp_ret  input  32  signed return code
rsp_data  input  DW  return data

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, state IDLE, RR pointer 0, eod 0, err 0, timeout counter 0. Asserting reset mid-call abandons the call with no done pulse.
- Eligible requester: req[i] & ~eod[i]. Requesters masked by eod are never granted; their req is ignored.
- IDLE: if any requester is eligible, pick the first eligible index at or after the pointer, wrapping modulo NREQ. Latch its index, fn and data. Go to ISSUE. Nothing eligible: stay in IDLE.
- ISSUE:
  - gnt[idx]=1 in the first ISSUE cycle only.
  - call_valid=1 with call_id=ID_BASE+idx and the latched fn/data, held stable until call_ready.
  - On call_valid&call_ready: clear call_valid, clear the counter, go to WAIT.
  - Minimum latency from req to call_valid is 1 cycle.
- WAIT:
  - The counter increments each cycle.
  - On rsp_valid: next cycle done[idx]=1, done_ret=rsp_ret, done_data=rsp_data. Then:
    - ret<0: set eod[idx].
    - ret>0: set err; load err_id if err was 0.
  - Pointer becomes idx+1 (wrapping). Go to IDLE.
  - Timeout, when the counter reaches TO_CYC without rsp_valid: done[idx]=1, done_ret=+1, done_data=0, set err and err_id. Pointer advances; go to IDLE.
  - rsp_valid on the timeout cycle: the response wins and no timeout is raised.
- rsp_valid outside WAIT is ignored.
- done is 0 except for one cycle per completed call; done_ret and done_data hold their last values otherwise.
- eod_clr[i] clears eod[i]. If eod_clr[i] and the set of eod[i] land in the same cycle, the set wins.
- err clears only on reset.
- Throughput: at most one outstanding call. Minimum 3 cycles per call with zero-latency call_ready and rsp_valid.

Test Plan:
1. Single requester, NREQ=4: req[2]=1, fn=0, data=5; ready and rsp_valid one cycle after call_valid; ret=0, rsp_data=1 -> gnt[2] pulses, call_id=2, call_fn=0, call_data=5, then done[2] with done_ret=0, done_data=1; eod and err stay 0.
2. All four req held high, immediate ready/rsp, ret=0 -> grant order 0,1,2,3,0; each done matches its grant index.
3. rsp_ret=-1 to requester 1 -> eod[1]=1. Requester 1 is skipped while others keep rotating. eod_clr[1] -> requester 1 is granted again on the next arbitration.
4. rsp_ret=3 to requester 0 and later rsp_ret=7 to requester 3 -> err=1, err_id=0 (first error retained), done_ret=3 then 7.
5. TO_CYC=4, rsp_valid withheld -> done pulse with done_ret=+1 on the 4th WAIT cycle, err=1. Variant with rsp_valid on that same cycle -> done_ret=rsp_ret and err stays 0.
6. call_ready held low 10 cycles with data changing on req_data -> call_fn/call_data stay at the latched values. Assert rst during WAIT -> all outputs 0, no done pulse; a fresh request after reset starts from requester 0.
